// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for the asynchronous FIFO and its pointer
// synchronisers.
//
// Contents:
//   MIN_SYNC_STAGES / MAX_SYNC_STAGES : legal depth of a synchroniser chain
//   MIN_PTR_W / MAX_PTR_W             : legal pointer width
//   ptr_t                             : pointer container of maximum width
//   gray2bin()                        : Gray to binary conversion
//   bin2gray()                        : binary to Gray conversion
//   gray_hamming()                    : number of bits differing between two
//                                       Gray values
//
// The conversion helpers work on a MAX_PTR_W-bit container. A narrower
// pointer is zero-extended on the way in and truncated on the way out. This
// gives the correct narrow result, because the zero bits above the real MSB
// contribute nothing to the XOR prefix of gray2bin or to the shift of
// bin2gray.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MIN_PTR_W       = 2;
    localparam int MAX_PTR_W       = 16;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // A legal Gray step changes exactly one bit. A larger count means the
    // source skipped values or a multi-bit pointer was sampled mid-change.
    function automatic logic [4:0] gray_hamming(input ptr_t a, input ptr_t b);
        ptr_t       x;
        logic [4:0] cnt;
        x   = a ^ b;
        cnt = 5'd0;
        for (int i = 0; i < MAX_PTR_W; i++) begin
            cnt = cnt + {4'd0, x[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//
// Generic N-stage, W-bit flop chain with asynchronous active-low reset.
// Used for clock-domain crossing of Gray pointers and as a reset
// synchroniser. Every stage carries ASYNC_REG, so implementation keeps the
// flops adjacent and does not retime them.
//
// Parameters:
//   W : data width in bits
//   N : number of flops in the chain (>= 1)
//
// Ports:
//   clk_i  : destination clock, rising edge
//   rst_ni : asynchronous active-low reset; clears every stage to 0
//   d_i    : data from the foreign domain (asynchronous to clk_i)
//   q_o    : output of the last stage, N edges after d_i settles
// ---------------------------------------------------------------------------
module sync_chain
    import fifo_pkg::*;
#(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (N < 1) begin : g_bad_depth
        $error("sync_chain: N=%0d must be at least 1", N);
    end

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage_q [N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/sync_ptr_gray.sv
// ---------------------------------------------------------------------------
// sync_ptr_gray
//
// Resynchronises a Gray-coded pointer from a foreign clock domain into wclk.
// It also provides a binary copy, an update pulse, the modular advance since
// the previous value, and a sticky flag for non-Gray movement. It is
// instantiated on both the read-to-write and the write-to-read paths of the
// async FIFO.
//
// Parameters:
//   PTR_W       : pointer width including the wrap bit (2..16)
//   SYNC_STAGES : synchroniser depth (2..4)
//   BIN_OUT_REG : 1 = binary/update/delta registered (one extra cycle)
//                 0 = binary/update/delta combinational, aligned with
//                     wq_rptr_gray
//
// Ports:
//   wclk          : destination clock, rising edge
//   wrst_n        : asynchronous active-low reset; clears all state
//   rptr_gray     : Gray pointer from the source domain
//   err_clr       : synchronous clear of gray_err
//   wq_rptr_gray  : synchronised Gray pointer (last chain stage)
//   wq_rptr_bin   : binary equivalent of the synchronised pointer
//   wq_rptr_upd   : one-cycle pulse on each change of the synchronised value
//   wq_rptr_delta : (new_bin - old_bin) mod 2^PTR_W; 0 when there is no
//                   change
//   gray_err      : sticky; set when the synchronised value moved by more
//                   than one Gray bit in one cycle
// ---------------------------------------------------------------------------
module sync_ptr_gray
    import fifo_pkg::*;
#(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int BIN_OUT_REG = 1
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [PTR_W-1:0] rptr_gray,
    input  logic             err_clr,
    output logic [PTR_W-1:0] wq_rptr_gray,
    output logic [PTR_W-1:0] wq_rptr_bin,
    output logic             wq_rptr_upd,
    output logic [PTR_W-1:0] wq_rptr_delta,
    output logic             gray_err
);

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("sync_ptr_gray: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end

    if (PTR_W < MIN_PTR_W || PTR_W > MAX_PTR_W) begin : g_bad_width
        $error("sync_ptr_gray: PTR_W=%0d outside %0d..%0d",
               PTR_W, MIN_PTR_W, MAX_PTR_W);
    end

    // -----------------------------------------------------------------------
    // Synchroniser chain
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] sync_gray;

    sync_chain #(
        .W (PTR_W),
        .N (SYNC_STAGES)
    ) u_sync_chain (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (rptr_gray),
        .q_o    (sync_gray)
    );

    assign wq_rptr_gray = sync_gray;

    // -----------------------------------------------------------------------
    // History. Reset loads 0, so the first compare after release is made
    // against the reset value.
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] prev_gray_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            prev_gray_q <= '0;
        end else begin
            prev_gray_q <= sync_gray;
        end
    end

    // -----------------------------------------------------------------------
    // Conversion, change detection and modular delta. The subtraction is
    // unsigned and PTR_W bits wide, so a wrap such as 1111 -> 0000 reports 1.
    // A non-Gray jump still reports its true modular distance.
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] cur_bin;
    logic [PTR_W-1:0] prev_bin;
    logic [PTR_W-1:0] delta_d;
    logic             chg;
    logic             viol;
    logic [4:0]       hd;

    always_comb begin
        cur_bin  = PTR_W'(gray2bin(ptr_t'(sync_gray)));
        prev_bin = PTR_W'(gray2bin(ptr_t'(prev_gray_q)));
        chg      = (sync_gray != prev_gray_q);
        hd       = gray_hamming(ptr_t'(sync_gray), ptr_t'(prev_gray_q));
        viol     = (hd > 5'd1);
        delta_d  = chg ? (cur_bin - prev_bin) : '0;
    end

    // -----------------------------------------------------------------------
    // Sticky violation flag. A new violation takes priority over a clear in
    // the same cycle, so an error is never lost. The flag is always
    // registered, whatever BIN_OUT_REG is.
    // -----------------------------------------------------------------------
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (viol) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign gray_err = err_q;

    // -----------------------------------------------------------------------
    // Output stage: registered (one extra cycle) or taken directly from the
    // last sync stage.
    // -----------------------------------------------------------------------
    if (BIN_OUT_REG != 0) begin : g_out_reg
        logic [PTR_W-1:0] bin_q;
        logic [PTR_W-1:0] delta_q;
        logic             upd_q;

        always_ff @(posedge wclk or negedge wrst_n) begin
            if (!wrst_n) begin
                bin_q   <= '0;
                upd_q   <= 1'b0;
                delta_q <= '0;
            end else begin
                bin_q   <= cur_bin;
                upd_q   <= chg;
                delta_q <= delta_d;
            end
        end

        assign wq_rptr_bin   = bin_q;
        assign wq_rptr_upd   = upd_q;
        assign wq_rptr_delta = delta_q;
    end else begin : g_out_comb
        assign wq_rptr_bin   = cur_bin;
        assign wq_rptr_upd   = chg;
        assign wq_rptr_delta = delta_d;
    end

endmodule

// File: tb/tb_sync_ptr_gray.sv
// ---------------------------------------------------------------------------
// tb_sync_ptr_gray
//
// Self-checking bench for sync_ptr_gray. dutA uses the defaults
// (PTR_W=4, SYNC_STAGES=2, BIN_OUT_REG=1). dutB is the swept configuration
// (PTR_W=6, SYNC_STAGES=3, BIN_OUT_REG=0).
//
// A table of {input Gray, expected binary-side result} records drives dutA.
// Each record is pushed to a scoreboard queue when its input is applied, and
// popped once the pipeline latency has elapsed. Hand-written sequences cover
// the exact latency, error clear and priority, the swept parameters, and a
// mid-stream asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sync_ptr_gray;

    localparam int WA    = 4;
    localparam int SSA   = 2;
    localparam int LAT_A = SSA + 1;
    localparam int WB    = 6;
    localparam int SSB   = 3;
    localparam int NVEC  = 24;

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic          wrst_n;
    logic [WA-1:0] rgA;
    logic          clrA;
    logic [WA-1:0] gA, bA, dA;
    logic          updA, errA;
    logic [WB-1:0] rgB;
    logic          clrB;
    logic [WB-1:0] gB, bB, dB;
    logic          updB, errB;

    sync_ptr_gray #(
        .PTR_W       (WA),
        .SYNC_STAGES (SSA),
        .BIN_OUT_REG (1)
    ) dutA (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .rptr_gray     (rgA),
        .err_clr       (clrA),
        .wq_rptr_gray  (gA),
        .wq_rptr_bin   (bA),
        .wq_rptr_upd   (updA),
        .wq_rptr_delta (dA),
        .gray_err      (errA)
    );

    sync_ptr_gray #(
        .PTR_W       (WB),
        .SYNC_STAGES (SSB),
        .BIN_OUT_REG (0)
    ) dutB (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .rptr_gray     (rgB),
        .err_clr       (clrB),
        .wq_rptr_gray  (gB),
        .wq_rptr_bin   (bB),
        .wq_rptr_upd   (updB),
        .wq_rptr_delta (dB),
        .gray_err      (errB)
    );

    typedef struct {
        logic [WA-1:0] g;
        logic [WA-1:0] bin;
        logic          upd;
        logic [WA-1:0] delta;
        logic          err;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t sbQ [$];
    int   checks = 0;
    int   errors = 0;
    int   rowOut = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic checkScoreboard();
        vec_t e;
        e = sbQ.pop_front();
        checkOutput($sformatf("tbl%0d_bin", rowOut), 16'(bA), 16'(e.bin));
        checkOutput($sformatf("tbl%0d_upd", rowOut), 16'(updA), 16'(e.upd));
        checkOutput($sformatf("tbl%0d_delta", rowOut), 16'(dA), 16'(e.delta));
        checkOutput($sformatf("tbl%0d_err", rowOut), 16'(errA), 16'(e.err));
        rowOut++;
    endtask

    task automatic applyStimulus(input vec_t v);
        rgA = v.g;
        sbQ.push_back(v);
        tick();
        if (sbQ.size() == LAT_A) checkScoreboard();
    endtask

    task automatic checkAllZeroA(input string tag);
        checkOutput({tag, "_gray"}, 16'(gA), 16'h0);
        checkOutput({tag, "_bin"}, 16'(bA), 16'h0);
        checkOutput({tag, "_upd"}, 16'(updA), 16'h0);
        checkOutput({tag, "_delta"}, 16'(dA), 16'h0);
        checkOutput({tag, "_err"}, 16'(errA), 16'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Table: input Gray, then the expected bin/upd/delta/err it produces.
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 4'd0,  1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 4'd0,  1'b0};
        vecs[2]  = '{4'b0001, 4'b0001, 1'b1, 4'd1,  1'b0};
        vecs[3]  = '{4'b0011, 4'b0010, 1'b1, 4'd1,  1'b0};
        vecs[4]  = '{4'b0010, 4'b0011, 1'b1, 4'd1,  1'b0};
        vecs[5]  = '{4'b0110, 4'b0100, 1'b1, 4'd1,  1'b0};
        vecs[6]  = '{4'b0110, 4'b0100, 1'b0, 4'd0,  1'b0};
        vecs[7]  = '{4'b0111, 4'b0101, 1'b1, 4'd1,  1'b0};
        vecs[8]  = '{4'b0101, 4'b0110, 1'b1, 4'd1,  1'b0};
        vecs[9]  = '{4'b0100, 4'b0111, 1'b1, 4'd1,  1'b0};
        vecs[10] = '{4'b1100, 4'b1000, 1'b1, 4'd1,  1'b0};
        vecs[11] = '{4'b1101, 4'b1001, 1'b1, 4'd1,  1'b0};
        vecs[12] = '{4'b1111, 4'b1010, 1'b1, 4'd1,  1'b0};
        vecs[13] = '{4'b1110, 4'b1011, 1'b1, 4'd1,  1'b0};
        vecs[14] = '{4'b1010, 4'b1100, 1'b1, 4'd1,  1'b0};
        vecs[15] = '{4'b1011, 4'b1101, 1'b1, 4'd1,  1'b0};
        vecs[16] = '{4'b1001, 4'b1110, 1'b1, 4'd1,  1'b0};
        vecs[17] = '{4'b1000, 4'b1111, 1'b1, 4'd1,  1'b0};
        vecs[18] = '{4'b0000, 4'b0000, 1'b1, 4'd1,  1'b0};
        vecs[19] = '{4'b0000, 4'b0000, 1'b0, 4'd0,  1'b0};
        vecs[20] = '{4'b0011, 4'b0010, 1'b1, 4'd2,  1'b1};
        vecs[21] = '{4'b0011, 4'b0010, 1'b0, 4'd0,  1'b1};
        vecs[22] = '{4'b1011, 4'b1101, 1'b1, 4'd11, 1'b1};
        vecs[23] = '{4'b0000, 4'b0000, 1'b1, 4'd3,  1'b1};

        wrst_n = 1'b0;
        rgA    = '0;
        clrA   = 1'b0;
        rgB    = '0;
        clrB   = 1'b0;

        // Reset values while held in reset
        tick();
        tick();
        checkAllZeroA("rst");
        checkOutput("rstB_gray", 16'(gB), 16'h0);
        checkOutput("rstB_err", 16'(errB), 16'h0);
        wrst_n = 1'b1;

        // Hold 0 for 10 cycles: everything stays 0
        for (int i = 0; i < 10; i++) begin
            tick();
            checkAllZeroA($sformatf("hold%0d", i));
        end

        // Single step 0000 -> 0001 with exact latency
        rgA = 4'b0001;
        tick();
        checkOutput("step_e1_gray", 16'(gA), 16'h0);
        tick();
        checkOutput("step_e2_gray", 16'(gA), 16'h1);
        checkOutput("step_e2_bin", 16'(bA), 16'h0);
        checkOutput("step_e2_upd", 16'(updA), 16'h0);
        tick();
        checkOutput("step_e3_bin", 16'(bA), 16'h1);
        checkOutput("step_e3_upd", 16'(updA), 16'h1);
        checkOutput("step_e3_delta", 16'(dA), 16'h1);
        tick();
        checkOutput("step_e4_upd", 16'(updA), 16'h0);
        checkOutput("step_e4_delta", 16'(dA), 16'h0);
        checkOutput("step_e4_bin", 16'(bA), 16'h1);

        // Back to 0 (legal step), let it settle
        rgA = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("settle_upd", 16'(updA), 16'h0);
        checkOutput("settle_err", 16'(errA), 16'h0);

        // Table-driven run through the scoreboard, then drain
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
        while (sbQ.size() > 0) begin
            tick();
            checkScoreboard();
        end

        // Error clear, and clear with nothing pending
        clrA = 1'b1;
        tick();
        checkOutput("clr_err", 16'(errA), 16'h0);
        clrA = 1'b0;
        clrA = 1'b1;
        tick();
        checkOutput("clr_idle_err", 16'(errA), 16'h0);
        clrA = 1'b0;

        // 0000 -> 0010 (bin 3), 0110 (bin 4), 0101 (bin 6, hd=2)
        rgA = 4'b0010;
        tick();
        tick();
        checkOutput("v_gray3", 16'(gA), 16'h2);
        tick();
        checkOutput("v_bin3", 16'(bA), 16'h3);
        checkOutput("v_delta3", 16'(dA), 16'h3);
        checkOutput("v_err3", 16'(errA), 16'h0);
        rgA = 4'b0110;
        tick();
        tick();
        tick();
        checkOutput("v_bin4", 16'(bA), 16'h4);
        checkOutput("v_delta4", 16'(dA), 16'h1);
        checkOutput("v_err4", 16'(errA), 16'h0);
        rgA = 4'b0101;
        tick();
        tick();
        checkOutput("v_gray6", 16'(gA), 16'h5);
        checkOutput("v_err_early", 16'(errA), 16'h0);
        tick();
        checkOutput("v_bin6", 16'(bA), 16'h6);
        checkOutput("v_upd6", 16'(updA), 16'h1);
        checkOutput("v_delta6", 16'(dA), 16'h2);
        checkOutput("v_err6", 16'(errA), 16'h1);
        tick();
        checkOutput("v_sticky", 16'(errA), 16'h1);
        checkOutput("v_upd_after", 16'(updA), 16'h0);
        clrA = 1'b1;
        tick();
        checkOutput("v_cleared", 16'(errA), 16'h0);
        clrA = 1'b0;

        // Clear coinciding with a new violation (0101 -> 0110, hd=2): set wins
        rgA = 4'b0110;
        tick();
        tick();
        clrA = 1'b1;
        tick();
        checkOutput("setwins_err", 16'(errA), 16'h1);
        checkOutput("setwins_delta", 16'(dA), 16'he);
        clrA = 1'b0;
        tick();
        checkOutput("setwins_hold", 16'(errA), 16'h1);

        // dutB: SYNC_STAGES=3, combinational outputs
        rgB = 6'b000001;
        tick();
        checkOutput("B_e1_gray", 16'(gB), 16'h0);
        tick();
        checkOutput("B_e2_gray", 16'(gB), 16'h0);
        checkOutput("B_e2_upd", 16'(updB), 16'h0);
        tick();
        checkOutput("B_e3_gray", 16'(gB), 16'h1);
        checkOutput("B_e3_bin", 16'(bB), 16'h1);
        checkOutput("B_e3_upd", 16'(updB), 16'h1);
        checkOutput("B_e3_delta", 16'(dB), 16'h1);
        tick();
        checkOutput("B_e4_upd", 16'(updB), 16'h0);
        checkOutput("B_e4_delta", 16'(dB), 16'h0);
        checkOutput("B_e4_bin", 16'(bB), 16'h1);
        rgB = 6'b000010;
        tick();
        tick();
        tick();
        checkOutput("B_v_bin", 16'(bB), 16'h3);
        checkOutput("B_v_delta", 16'(dB), 16'h2);
        checkOutput("B_v_err_early", 16'(errB), 16'h0);
        tick();
        checkOutput("B_v_err", 16'(errB), 16'h1);
        checkOutput("B_v_upd_after", 16'(updB), 16'h0);
        clrB = 1'b1;
        tick();
        checkOutput("B_clr", 16'(errB), 16'h0);
        clrB = 1'b0;

        // Mid-stream reset while at bin 5, gray_err still set
        rgA = 4'b0111;
        tick();
        tick();
        tick();
        checkOutput("pre_rst_bin", 16'(bA), 16'h5);
        checkOutput("pre_rst_err", 16'(errA), 16'h1);
        #2;
        wrst_n = 1'b0;
        #1;
        checkAllZeroA("async_rst");
        tick();
        wrst_n = 1'b1;
        tick();
        checkOutput("rel_e1_gray", 16'(gA), 16'h0);
        checkOutput("rel_e1_upd", 16'(updA), 16'h0);
        tick();
        checkOutput("rel_e2_gray", 16'(gA), 16'h7);
        checkOutput("rel_e2_bin", 16'(bA), 16'h0);
        checkOutput("rel_e2_err", 16'(errA), 16'h0);
        tick();
        checkOutput("rel_e3_bin", 16'(bA), 16'h5);
        checkOutput("rel_e3_upd", 16'(updA), 16'h1);
        checkOutput("rel_e3_delta", 16'(dA), 16'h5);
        checkOutput("rel_e3_err", 16'(errA), 16'h1);
        tick();
        checkOutput("rel_e4_upd", 16'(updA), 16'h0);
        checkOutput("rel_e4_delta", 16'(dA), 16'h0);
        checkOutput("rel_e4_err", 16'(errA), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
